// File: rtl/ram_port_arbiter.sv
// Four-way arbiter (fetch/data ports of two cores) sharing one RAM port.
// Define ARB_STARVE_GUARD_EN to let a pending fetch win after STARVE_MAX data grants.
module ram_port_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [1:0]             iREN,
  input  logic [1:0][WORD_W-1:0] iaddr,
  output logic [1:0]             iwait,
  output logic [1:0][WORD_W-1:0] iload,
  input  logic [1:0]             dREN,
  input  logic [1:0]             dWEN,
  input  logic [1:0][WORD_W-1:0] daddr,
  input  logic [1:0][WORD_W-1:0] dstore,
  output logic [1:0]             dwait,
  output logic [1:0][WORD_W-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic                   ramerr
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  if (STARVE_MAX < 1) begin : g_cfg_check
    $error("STARVE_MAX must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, GRANT, BURST2} state_t;

  state_t state_q, state_d;
  logic   cls_q, cls_d;      // 1 = data port, 0 = fetch port
  logic   core_q, core_d;
  logic   iptr_q, iptr_d;
  logic   dptr_q, dptr_d;
  logic   ramerr_q, ramerr_d;

  logic [1:0] dreq;
  logic       any_i, any_d;
  logic       pick_fetch;
  logic       win_i, win_d;
  logic       win_req, live, done;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;
`endif

  assign dreq  = dREN | dWEN;
  assign any_i = |iREN;
  assign any_d = |dreq;
  assign win_i = iREN[iptr_q] ? iptr_q : ~iptr_q;
  assign win_d = dreq[dptr_q] ? dptr_q : ~dptr_q;

`ifdef ARB_STARVE_GUARD_EN
  assign pick_fetch = any_i && (!any_d || (starve_q == SW'(STARVE_MAX)));
`else
  assign pick_fetch = any_i && !any_d;
`endif

  // A withdrawn request drops the drive immediately, before the FSM sees it.
  assign win_req = cls_q ? dreq[core_q] : iREN[core_q];
  assign live    = (state_q != IDLE) && win_req;
  assign done    = live && ((ramstate == RS_ACCESS) || (ramstate == RS_ERROR));
  assign ramerr  = ramerr_q;

  always_comb begin
    iwait    = 2'b11;
    dwait    = 2'b11;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (live) begin
      ramWEN   = cls_q & dWEN[core_q];
      ramREN   = ~(cls_q & dWEN[core_q]);
      ramaddr  = cls_q ? daddr[core_q] : iaddr[core_q];
      ramstore = cls_q ? dstore[core_q] : '0;
    end
    if (done) begin
      if (cls_q) begin
        dwait[core_q] = 1'b0;
        dload[core_q] = ramload;
      end else begin
        iwait[core_q] = 1'b0;
        iload[core_q] = ramload;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    core_d   = core_q;
    iptr_d   = iptr_q;
    dptr_d   = dptr_q;
    ramerr_d = ramerr_q | ((state_q != IDLE) && (ramstate == RS_ERROR));
`ifdef ARB_STARVE_GUARD_EN
    starve_d = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_i || any_d) begin
          state_d = GRANT;
          cls_d   = ~pick_fetch;
          if (pick_fetch) begin
            core_d = win_i;
            iptr_d = ~win_i;
          end else begin
            core_d = win_d;
            dptr_d = ~win_d;
          end
`ifdef ARB_STARVE_GUARD_EN
          if (pick_fetch || !any_i) starve_d = '0;
          else                      starve_d = starve_q + 1'b1;
`endif
        end
      end
      GRANT: begin
        if (!win_req)  state_d = IDLE;
        else if (done) state_d = cls_q ? BURST2 : IDLE;
      end
      BURST2: begin
        if (!win_req || done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cls_q    <= 1'b0;
      core_q   <= 1'b0;
      iptr_q   <= 1'b0;
      dptr_q   <= 1'b0;
      ramerr_q <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      core_q   <= core_d;
      iptr_q   <= iptr_d;
      dptr_q   <= dptr_d;
      ramerr_q <= ramerr_d;
`ifdef ARB_STARVE_GUARD_EN
      starve_q <= starve_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: vector table of single transfers plus hand-built
// sequences, with a completion scoreboard watching the wait lines.
module tb_ram_port_arbiter;
  localparam int W = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [1:0]       iREN = '0;
  logic [1:0][W-1:0] iaddr = '0;
  logic [1:0]       iwait;
  logic [1:0][W-1:0] iload;
  logic [1:0]       dREN = '0;
  logic [1:0]       dWEN = '0;
  logic [1:0][W-1:0] daddr = '0;
  logic [1:0][W-1:0] dstore = '0;
  logic [1:0]       dwait;
  logic [1:0][W-1:0] dload;
  logic             ramREN, ramWEN;
  logic [W-1:0]     ramaddr, ramstore;
  logic [W-1:0]     ramload = '0;
  logic [1:0]       ramstate = FREE;
  logic             ramerr;

  ram_port_arbiter #(.WORD_W(W), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] id;     // {data, core}
    logic [W-1:0] addr;
    logic [W-1:0] load;
  } exp_t;

  typedef struct {
    logic cls;
    logic core;
    logic re;
    logic we;
    logic [W-1:0] addr;
    logic [W-1:0] store;
    logic [W-1:0] load;
    int busy;
  } vec_t;

  exp_t expq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [W-1:0] a, input logic [W-1:0] l);
    exp_t e;
    e.id = id; e.addr = a; e.load = l;
    expq.push_back(e);
  endtask

  // Scoreboard: every wait-low pulse consumes the oldest expected completion.
  exp_t       m_e;
  logic [3:0] m_done;
  logic [W-1:0] m_load;
  always @(negedge CLK) begin
    if (!RST) begin
      m_done = {~dwait[1], ~dwait[0], ~iwait[1], ~iwait[0]};
      if (m_done != 4'b0) begin
        chk("one_wait_low", 32'($countones(m_done)), 32'd1);
        if (expq.size() == 0) begin
          chk("unexpected_wait", {28'd0, m_done}, 32'd0);
        end else begin
          m_e = expq.pop_front();
          m_load = m_e.id[1] ? dload[m_e.id[0]] : iload[m_e.id[0]];
          chk("sb_who", {28'd0, m_done}, 32'd1 << m_e.id);
          chk("sb_addr", ramaddr, m_e.addr);
          chk("sb_load", m_load, m_e.load);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_inputs();
    iREN = '0; dREN = '0; dWEN = '0; ramstate = FREE;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  task automatic drain(input string name);
    chk(name, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  task automatic do_access(input vec_t v, input int idx);
    int nw;
    logic wb;
    nw = v.cls ? 2 : 1;
    if (v.cls) begin
      dREN[v.core] = v.re; dWEN[v.core] = v.we;
      daddr[v.core] = v.addr; dstore[v.core] = v.store;
    end else begin
      iREN[v.core] = 1'b1; iaddr[v.core] = v.addr;
    end
    ramstate = FREE;
    push({v.cls, v.core}, v.addr, v.load);
    if (v.cls) push({v.cls, v.core}, v.addr + 32'd4, ~v.load);
    for (int w = 0; w < nw; w++) begin
      for (int c = 0; c <= v.busy; c++) begin
        step();
        if (w == 1 && c == 0) begin
          daddr[v.core] = v.addr + 32'd4;
          dstore[v.core] = ~v.store;
        end
        ramload  = (w == 0) ? v.load : ~v.load;
        ramstate = (c == v.busy) ? ACCESS : BUSY;
        #1;
        chk($sformatf("v%0d_ren", idx), {31'd0, ramREN}, v.cls ? {31'd0, v.re & ~v.we} : 32'd1);
        chk($sformatf("v%0d_wen", idx), {31'd0, ramWEN}, {31'd0, v.cls & v.we});
        chk($sformatf("v%0d_addr", idx), ramaddr, v.addr + 32'(4 * w));
        if (v.cls && v.we)
          chk($sformatf("v%0d_store", idx), ramstore, (w == 1) ? ~v.store : v.store);
        if (c < v.busy) begin
          wb = v.cls ? dwait[v.core] : iwait[v.core];
          chk($sformatf("v%0d_wait_hi", idx), {31'd0, wb}, 32'd1);
        end
      end
    end
    step();
    clear_inputs();
    #1;
    chk($sformatf("v%0d_idle_en", idx), {30'd0, ramREN, ramWEN}, 32'd0);
    drain($sformatf("v%0d_drain", idx));
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{cls:1'b0, core:1'b0, re:1'b0, we:1'b0, addr:32'h40,  store:32'h0,        load:32'hDEADBEEF, busy:2};
    vt[1] = '{cls:1'b0, core:1'b1, re:1'b0, we:1'b0, addr:32'h80,  store:32'h0,        load:32'h12345678, busy:0};
    vt[2] = '{cls:1'b1, core:1'b0, re:1'b1, we:1'b0, addr:32'h200, store:32'h0,        load:32'hA5A50001, busy:1};
    vt[3] = '{cls:1'b1, core:1'b1, re:1'b0, we:1'b1, addr:32'h100, store:32'hCAFE0000, load:32'h0BAD0000, busy:0};
    vt[4] = '{cls:1'b1, core:1'b0, re:1'b1, we:1'b1, addr:32'h300, store:32'h11112222, load:32'h00000055, busy:1};

    #3;
    chk("rst_iwait", {30'd0, iwait}, 32'd3);
    chk("rst_dwait", {30'd0, dwait}, 32'd3);
    chk("rst_en", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("rst_addr", ramaddr, 32'd0);
    chk("rst_store", ramstore, 32'd0);
    chk("rst_iload", iload[0] | iload[1], 32'd0);
    chk("rst_dload", dload[0] | dload[1], 32'd0);
    chk("rst_err", {31'd0, ramerr}, 32'd0);
    step();
    RST = 1'b0;

    for (int i = 0; i < 5; i++) do_access(vt[i], i);

    // Core 1 data burst; core 1 fetch raised alongside must wait for IDLE.
    dWEN[1] = 1'b1; daddr[1] = 32'h100; dstore[1] = 32'hAAAA0001;
    iREN[1] = 1'b1; iaddr[1] = 32'h1C0;
    ramstate = ACCESS; ramload = 32'h77;
    push(2'b11, 32'h100, 32'h77); push(2'b11, 32'h104, 32'h77); push(2'b01, 32'h1C0, 32'h77);
    step(); #1;
    chk("burst_wen1", {31'd0, ramWEN}, 32'd1);
    chk("burst_ifetch_held", {31'd0, iwait[1]}, 32'd1);
    step(); daddr[1] = 32'h104; #1;
    chk("burst_wen2", {31'd0, ramWEN}, 32'd1);
    chk("burst_addr2", ramaddr, 32'h104);
    step(); dWEN[1] = 1'b0; #1;
    chk("burst_dead", {30'd0, ramREN, ramWEN}, 32'd0);
    step(); #1;
    chk("burst_fetch_ren", {31'd0, ramREN}, 32'd1);
    step(); iREN = '0;
    step();
    drain("burst_drain");

    // Data round-robin from reset.
    do_reset();
    dREN = 2'b11; daddr[0] = 32'h300; daddr[1] = 32'h400;
    ramstate = ACCESS; ramload = 32'h99;
    for (int k = 0; k < 4; k++) begin
      push({1'b1, k[0]}, k[0] ? 32'h400 : 32'h300, 32'h99);
      push({1'b1, k[0]}, k[0] ? 32'h400 : 32'h300, 32'h99);
    end
    repeat (12) step();
    dREN = '0;
    step();
    drain("rr_data_drain");

    // Fetch round-robin from reset.
    do_reset();
    iREN = 2'b11; iaddr[0] = 32'h500; iaddr[1] = 32'h600;
    ramstate = ACCESS; ramload = 32'h5A;
    for (int k = 0; k < 4; k++) push({1'b0, k[0]}, k[0] ? 32'h600 : 32'h500, 32'h5A);
    repeat (8) step();
    iREN = '0;
    step();
    drain("rr_fetch_drain");

    // Starvation: data held on both cores with a core 0 fetch pending.
    do_reset();
    dREN = 2'b11; iREN = 2'b01; iaddr[0] = 32'h700;
    ramstate = ACCESS; ramload = 32'h3C;
`ifdef ARB_STARVE_GUARD_EN
    for (int k = 0; k < 4; k++) begin
      push({1'b1, k[0]}, k[0] ? 32'h400 : 32'h300, 32'h3C);
      push({1'b1, k[0]}, k[0] ? 32'h400 : 32'h300, 32'h3C);
    end
    push(2'b00, 32'h700, 32'h3C);
    repeat (14) step();
`else
    for (int k = 0; k < 5; k++) begin
      push({1'b1, k[0]}, k[0] ? 32'h400 : 32'h300, 32'h3C);
      push({1'b1, k[0]}, k[0] ? 32'h400 : 32'h300, 32'h3C);
    end
    repeat (15) step();
`endif
    clear_inputs();
    step();
    drain("starve_drain");

    // Withdrawal during BURST2.
    dREN[0] = 1'b1; daddr[0] = 32'h800; ramstate = ACCESS; ramload = 32'h42;
    push(2'b10, 32'h800, 32'h42);
    step(); #1;
    chk("wd_ren_grant", {31'd0, ramREN}, 32'd1);
    step(); dREN[0] = 1'b0; #1;
    chk("wd_ren_drop", {31'd0, ramREN}, 32'd0);
    chk("wd_dwait", {30'd0, dwait}, 32'd3);
    step(); iREN[0] = 1'b1; iaddr[0] = 32'h840;
    push(2'b00, 32'h840, 32'h42);
    #1;
    chk("wd_idle_en", {30'd0, ramREN, ramWEN}, 32'd0);
    step(); #1;
    chk("wd_next_ren", {31'd0, ramREN}, 32'd1);
    chk("wd_next_addr", ramaddr, 32'h840);
    step(); iREN = '0;
    step();
    drain("wd_drain");

    // Error response on a fetch.
    iREN[1] = 1'b1; iaddr[1] = 32'h900; ramstate = ERROR; ramload = 32'hE0;
    push(2'b01, 32'h900, 32'hE0);
    #1;
    chk("err_pre", {31'd0, ramerr}, 32'd0);
    step();
    step(); iREN = '0; ramstate = FREE; #1;
    chk("err_set", {31'd0, ramerr}, 32'd1);
    repeat (3) step();
    chk("err_sticky", {31'd0, ramerr}, 32'd1);
    drain("err_drain");

    // Reset in the middle of a write grant.
    dWEN[0] = 1'b1; daddr[0] = 32'hA00; dstore[0] = 32'h5555; ramstate = BUSY;
    step(); #1;
    chk("mid_wen", {31'd0, ramWEN}, 32'd1);
    #1 RST = 1'b1;
    #1;
    chk("mid_rst_en", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("mid_rst_waits", {28'd0, iwait, dwait}, 32'hF);
    chk("mid_rst_addr", ramaddr, 32'd0);
    chk("mid_rst_store", ramstore, 32'd0);
    chk("mid_rst_err", {31'd0, ramerr}, 32'd0);
    step();
    RST = 1'b0;
    dWEN = 2'b11; daddr[1] = 32'hB00; ramstate = ACCESS; ramload = 32'h31;
    push(2'b10, 32'hA00, 32'h31); push(2'b10, 32'hA00, 32'h31);
    step(); step(); step();
    dWEN = '0;
    step();
    drain("mid_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
